// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : tetris_pkg
//  Description : Shared playfield defaults, spawn point, move-command codes
//                and the move-controller state encoding.
//  Contents    : BOARD_W_DEF / BOARD_H_DEF   playfield size defaults
//                SPAWN_ROW_DEF / SPAWN_COL_DEF spawn pivot defaults
//                CMD_*                        3-bit move command codes
//                state_e                      move-controller states
//  Revision    : 1.0  initial release
// ============================================================================
package tetris_pkg;

   localparam int BOARD_W_DEF   = 10;
   localparam int BOARD_H_DEF   = 20;
   localparam int SPAWN_ROW_DEF = 1;
   localparam int SPAWN_COL_DEF = 4;

   localparam logic [2:0] CMD_LEFT  = 3'd0;
   localparam logic [2:0] CMD_RIGHT = 3'd1;
   localparam logic [2:0] CMD_ROT   = 3'd2;
   localparam logic [2:0] CMD_DOWN  = 3'd3;
   localparam logic [2:0] CMD_SPAWN = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHAPE  = 3'd1,
      ST_PROBE  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DECIDE = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/tetron_move_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : tetron_move_ctrl_if
//  Description : Move-command channel between the input/gravity logic
//                (master) and the move controller (slave).
//  Signals     : cmd_valid / cmd_ready / cmd[2:0]  command handshake
//                res_valid / res_ok                one-cycle move result
//  Revision    : 1.0  initial release
// ============================================================================
interface tetron_move_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd;
   logic       res_valid;
   logic       res_ok;

   modport master (output cmd_valid, cmd, input cmd_ready, res_valid, res_ok);
   modport slave  (input cmd_valid, cmd, output cmd_ready, res_valid, res_ok);
endinterface
`default_nettype wire

// File: rtl/tetron_cell_addr.sv
`default_nettype none
// ============================================================================
//  Module      : tetron_cell_addr
//  Description : Pivot + block offset (5-bit wrap) and playfield range check.
//  Ports       : i_pivot_row/col  candidate pivot
//                i_voffset/hoffset two's-complement block offset
//                o_row/o_col      resulting cell address
//                o_oob            cell lies outside the playfield
//  Revision    : 1.0  initial release
// ============================================================================
module tetron_cell_addr #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20
) (
   input  logic [4:0] i_pivot_row,
   input  logic [4:0] i_pivot_col,
   input  logic [4:0] i_voffset,
   input  logic [4:0] i_hoffset,
   output logic [4:0] o_row,
   output logic [4:0] o_col,
   output logic       o_oob
);
   localparam logic [4:0] c_board_w = 5'(BOARD_W);
   localparam logic [4:0] c_board_h = 5'(BOARD_H);

   logic [4:0] w_row;
   logic [4:0] w_col;

   assign w_row = i_pivot_row + i_voffset;
   assign w_col = i_pivot_col + i_hoffset;

   // A negative result wraps to 31 and is caught by the unsigned compare.
   assign o_row = w_row;
   assign o_col = w_col;
   assign o_oob = (w_row >= c_board_h) || (w_col >= c_board_w);
endmodule
`default_nettype wire

// File: rtl/tetron_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tetron_move_ctrl
//  Description : Sequences moves of the active tetromino: latches a candidate
//                pose, presents its rotation to the shaper, probes the four
//                resulting cells through a 1-cycle board read port, then
//                commits or rejects and reports lock / game-over.
//  Ports       : clk, rst                 clock, sync active-high reset
//                cmd_if (slave)           command handshake + result pulse
//                o_shp_active/rotation    to shaper
//                i_shp_blk{1..4}_*offset  from shaper
//                o_board_rd_en/row/col    board read request
//                i_board_rd_occ           occupancy, cycle after request
//                o_pos_row/col, o_rot     committed pose
//                o_live, o_lock, o_game_over  piece status
//  Revision    : 1.0  initial release
// ============================================================================
module tetron_move_ctrl
   import tetris_pkg::*;
#(
   parameter int BOARD_W   = BOARD_W_DEF,
   parameter int BOARD_H   = BOARD_H_DEF,
   parameter int SPAWN_ROW = SPAWN_ROW_DEF,
   parameter int SPAWN_COL = SPAWN_COL_DEF
) (
   input  logic       clk,
   input  logic       rst,
   tetron_move_ctrl_if.slave cmd_if,
   output logic       o_shp_active,
   output logic [2:0] o_shp_rotation,
   input  logic [4:0] i_shp_blk1_voffset,
   input  logic [4:0] i_shp_blk1_hoffset,
   input  logic [4:0] i_shp_blk2_voffset,
   input  logic [4:0] i_shp_blk2_hoffset,
   input  logic [4:0] i_shp_blk3_voffset,
   input  logic [4:0] i_shp_blk3_hoffset,
   input  logic [4:0] i_shp_blk4_voffset,
   input  logic [4:0] i_shp_blk4_hoffset,
   output logic       o_board_rd_en,
   output logic [4:0] o_board_rd_row,
   output logic [4:0] o_board_rd_col,
   input  logic       i_board_rd_occ,
   output logic [4:0] o_pos_row,
   output logic [4:0] o_pos_col,
   output logic [1:0] o_rot,
   output logic       o_live,
   output logic       o_lock,
   output logic       o_game_over
);
   state_e     r_state, w_state_next;
   logic [1:0] r_idx;
   logic [4:0] r_cand_row, r_cand_col;
   logic [1:0] r_cand_rot;
   logic [2:0] r_cmd;
   logic       r_force_fail, r_coll, r_rd_pend;
   logic [4:0] r_pos_row, r_pos_col;
   logic [1:0] r_rot;
   logic       r_live, r_res_valid, r_res_ok, r_lock, r_game_over;

   logic       w_accept, w_cmd_ready, w_probe, w_oob, w_ok;
   logic [4:0] w_voff, w_hoff, w_row, w_col;
   logic [4:0] w_nxt_row, w_nxt_col;
   logic [1:0] w_nxt_rot;
   logic       w_nxt_force;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (cmd_if.cmd_valid) w_state_next = ST_SHAPE;
         ST_SHAPE:  w_state_next = ST_PROBE;
         ST_PROBE:  if (r_idx == 2'd3) w_state_next = ST_DRAIN;
         ST_DRAIN:  w_state_next = ST_DECIDE;
         ST_DECIDE: w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_cmd_ready = (r_state == ST_IDLE);
      w_probe     = (r_state == ST_PROBE);
   end

   assign w_accept = cmd_if.cmd_valid && w_cmd_ready;

   // Candidate pose computed from the committed pose at accept time.
   always_comb begin
      w_nxt_row = r_pos_row;
      w_nxt_col = r_pos_col;
      w_nxt_rot = r_rot;
      case (cmd_if.cmd)
         CMD_LEFT:  w_nxt_col = r_pos_col - 5'd1;
         CMD_RIGHT: w_nxt_col = r_pos_col + 5'd1;
         CMD_ROT:   w_nxt_rot = r_rot + 2'd1;
         CMD_DOWN:  w_nxt_row = r_pos_row + 5'd1;
         CMD_SPAWN: begin
            w_nxt_row = 5'(SPAWN_ROW);
            w_nxt_col = 5'(SPAWN_COL);
            w_nxt_rot = 2'd0;
         end
         default: ;
      endcase
      // The pipeline always runs; these cases are only vetoed at DECIDE.
      w_nxt_force = (cmd_if.cmd > CMD_SPAWN) || r_game_over ||
                    ((cmd_if.cmd != CMD_SPAWN) && !r_live);
   end

   // Offsets of the block currently being probed.
   always_comb begin
      case (r_idx)
         2'd0:    begin w_voff = i_shp_blk1_voffset; w_hoff = i_shp_blk1_hoffset; end
         2'd1:    begin w_voff = i_shp_blk2_voffset; w_hoff = i_shp_blk2_hoffset; end
         2'd2:    begin w_voff = i_shp_blk3_voffset; w_hoff = i_shp_blk3_hoffset; end
         default: begin w_voff = i_shp_blk4_voffset; w_hoff = i_shp_blk4_hoffset; end
      endcase
   end

   tetron_cell_addr #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_cell_addr (
      .i_pivot_row (r_cand_row),
      .i_pivot_col (r_cand_col),
      .i_voffset   (w_voff),
      .i_hoffset   (w_hoff),
      .o_row       (w_row),
      .o_col       (w_col),
      .o_oob       (w_oob)
   );

   assign w_ok = !r_coll && !r_force_fail;

   // ---------------- Datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx        <= 2'd0;
         r_cand_row   <= 5'd0;
         r_cand_col   <= 5'd0;
         r_cand_rot   <= 2'd0;
         r_cmd        <= 3'd0;
         r_force_fail <= 1'b0;
         r_coll       <= 1'b0;
         r_rd_pend    <= 1'b0;
         r_pos_row    <= 5'd0;
         r_pos_col    <= 5'd0;
         r_rot        <= 2'd0;
         r_live       <= 1'b0;
         r_res_valid  <= 1'b0;
         r_res_ok     <= 1'b0;
         r_lock       <= 1'b0;
         r_game_over  <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         r_res_ok    <= 1'b0;
         r_lock      <= 1'b0;
         r_rd_pend   <= w_probe;
         if (w_accept) begin
            r_cand_row   <= w_nxt_row;
            r_cand_col   <= w_nxt_col;
            r_cand_rot   <= w_nxt_rot;
            r_cmd        <= cmd_if.cmd;
            r_force_fail <= w_nxt_force;
            r_coll       <= 1'b0;
            r_idx        <= 2'd0;
         end else begin
            // Range hits land during the probe; occupancy lands one cycle later.
            r_coll <= r_coll | (w_probe & w_oob) | (r_rd_pend & i_board_rd_occ);
            if (w_probe) r_idx <= r_idx + 2'd1;
         end
         if (r_state == ST_DECIDE) begin
            r_res_valid <= 1'b1;
            r_res_ok    <= w_ok;
            if (w_ok) begin
               r_pos_row <= r_cand_row;
               r_pos_col <= r_cand_col;
               r_rot     <= r_cand_rot;
               if (r_cmd == CMD_SPAWN) r_live <= 1'b1;
            end else if (r_coll && !r_force_fail) begin
               if (r_cmd == CMD_DOWN) begin
                  r_lock <= 1'b1;
                  r_live <= 1'b0;
               end
               if (r_cmd == CMD_SPAWN) begin
                  r_game_over <= 1'b1;
                  r_live      <= 1'b0;
               end
            end
         end
      end
   end

   assign cmd_if.cmd_ready = w_cmd_ready;
   assign cmd_if.res_valid = r_res_valid;
   assign cmd_if.res_ok    = r_res_ok;
   assign o_shp_active     = r_live || (r_state != ST_IDLE);
   assign o_shp_rotation   = {1'b0, r_cand_rot};
   assign o_board_rd_en    = w_probe;
   assign o_board_rd_row   = w_row;
   assign o_board_rd_col   = w_col;
   assign o_pos_row        = r_pos_row;
   assign o_pos_col        = r_pos_col;
   assign o_rot            = r_rot;
   assign o_live           = r_live;
   assign o_lock           = r_lock;
   assign o_game_over      = r_game_over;
endmodule
`default_nettype wire

// File: tb/tb_tetron_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tetron_move_ctrl
//  Description : Self-checking bench for tetron_move_ctrl with a shaper and
//                board-RAM model and a pose-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tetron_move_ctrl;
   localparam int W = 10;
   localparam int H = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tetron_move_ctrl_if cmd_if();

   logic       shp_active;
   logic [2:0] shp_rotation;
   logic [4:0] v1, h1, v2, h2, v3, h3, v4, h4;
   logic       rd_en, occ;
   logic [4:0] rd_row, rd_col;
   logic [4:0] pos_row, pos_col;
   logic [1:0] rot;
   logic       live, lock, game_over;

   tetron_move_ctrl #(.BOARD_W(W), .BOARD_H(H), .SPAWN_ROW(1), .SPAWN_COL(4)) dut (
      .clk(clk), .rst(rst), .cmd_if(cmd_if),
      .o_shp_active(shp_active), .o_shp_rotation(shp_rotation),
      .i_shp_blk1_voffset(v1), .i_shp_blk1_hoffset(h1),
      .i_shp_blk2_voffset(v2), .i_shp_blk2_hoffset(h2),
      .i_shp_blk3_voffset(v3), .i_shp_blk3_hoffset(h3),
      .i_shp_blk4_voffset(v4), .i_shp_blk4_hoffset(h4),
      .o_board_rd_en(rd_en), .o_board_rd_row(rd_row), .o_board_rd_col(rd_col),
      .i_board_rd_occ(occ),
      .o_pos_row(pos_row), .o_pos_col(pos_col), .o_rot(rot),
      .o_live(live), .o_lock(lock), .o_game_over(game_over)
   );

   // Piece shape: rotation 0 offsets (0,0),(0,+1),(0,-1),(-1,-1); each
   // rotation step maps (dr,dc) -> (dc,-dr).
   function automatic void blk_off(input int r, input int b, output int dr, output int dc);
      int t;
      dr = (b == 3) ? -1 : 0;
      dc = (b == 0) ? 0 : (b == 1) ? 1 : -1;
      for (int k = 0; k < r; k++) begin
         t = dr; dr = dc; dc = -t;
      end
   endfunction

   function automatic logic [9:0] shp_word(input int r, input int b);
      int dr, dc;
      blk_off(r, b, dr, dc);
      return {5'(dr), 5'(dc)};
   endfunction

   logic [1:0] shp_q;
   always @(posedge clk) begin
      if (rst) shp_q <= 2'd0;
      else if (shp_active) shp_q <= shp_rotation[1:0];
   end
   assign {v1, h1} = shp_word(int'(shp_q), 0);
   assign {v2, h2} = shp_word(int'(shp_q), 1);
   assign {v3, h3} = shp_word(int'(shp_q), 2);
   assign {v4, h4} = shp_word(int'(shp_q), 3);

   // Board RAM: 1-cycle read latency, random garbage when not read.
   logic board [0:31][0:31];
   always @(posedge clk) occ <= rd_en ? board[rd_row][rd_col] : 1'($urandom % 2);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_row, m_col, m_rot, m_live, m_go;
   int e_r[4], e_c[4], e_rot;

   task automatic model_reset();
      m_row = 0; m_col = 0; m_rot = 0; m_live = 0; m_go = 0;
   endtask

   task automatic predict(input int c, output bit ok, output bit lk);
      int cr, cc, dr, dc;
      bit frc, coll;
      cr = m_row; cc = m_col; e_rot = m_rot;
      case (c)
         0: cc = (cc + 31) % 32;
         1: cc = (cc + 1) % 32;
         2: e_rot = (e_rot + 1) % 4;
         3: cr = (cr + 1) % 32;
         4: begin cr = 1; cc = 4; e_rot = 0; end
         default: ;
      endcase
      frc  = (c > 4) || (m_go != 0) || (c != 4 && m_live == 0);
      coll = 0;
      for (int b = 0; b < 4; b++) begin
         blk_off(e_rot, b, dr, dc);
         e_r[b] = (cr + dr + 32) % 32;
         e_c[b] = (cc + dc + 32) % 32;
         if (e_r[b] >= H || e_c[b] >= W || board[e_r[b]][e_c[b]]) coll = 1;
      end
      ok = !coll && !frc;
      lk = 0;
      if (ok) begin
         m_row = cr; m_col = cc; m_rot = e_rot;
         if (c == 4) m_live = 1;
      end else if (coll && !frc) begin
         if (c == 3) begin lk = 1; m_live = 0; end
         if (c == 4) begin m_go = 1; m_live = 0; end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic run_cmd(input int c);
      bit ok, lk, busy_bad;
      predict(c, ok, lk);
      busy_bad = 0;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd       = 3'(c);
      @(posedge clk); #1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         if (cyc > 1) begin @(posedge clk); #1; end
         if (cyc <= 7) begin
            // Requests while busy must be ignored.
            cmd_if.cmd_valid = 1'($urandom % 2);
            cmd_if.cmd       = 3'($urandom % 8);
            if (cmd_if.res_valid !== 1'b0 || cmd_if.cmd_ready !== 1'b0) busy_bad = 1;
         end else begin
            cmd_if.cmd_valid = 1'b0;
         end
         if (cyc <= 5) chk("shp_rotation", shp_rotation, 32'(e_rot));
         if (cyc >= 2 && cyc <= 5) begin
            chk("rd_en", rd_en, 1);
            chk("rd_row", rd_row, 32'(e_r[cyc-2]));
            chk("rd_col", rd_col, 32'(e_c[cyc-2]));
         end
      end
      chk("busy_quiet", busy_bad, 0);
      chk("res_valid", cmd_if.res_valid, 1);
      chk("res_ok", cmd_if.res_ok, ok);
      chk("lock", lock, lk);
      chk("pos_row", pos_row, 32'(m_row));
      chk("pos_col", pos_col, 32'(m_col));
      chk("rot", rot, 32'(m_rot));
      chk("live", live, 32'(m_live));
      chk("game_over", game_over, 32'(m_go));
      chk("cmd_ready", cmd_if.cmd_ready, 1);
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_pos_row"}, pos_row, 0);
      chk({pfx, "_pos_col"}, pos_col, 0);
      chk({pfx, "_rot"}, rot, 0);
      chk({pfx, "_live"}, live, 0);
      chk({pfx, "_res_valid"}, cmd_if.res_valid, 0);
      chk({pfx, "_res_ok"}, cmd_if.res_ok, 0);
      chk({pfx, "_lock"}, lock, 0);
      chk({pfx, "_game_over"}, game_over, 0);
      chk({pfx, "_rd_en"}, rd_en, 0);
      chk({pfx, "_shp_active"}, shp_active, 0);
      chk({pfx, "_cmd_ready"}, cmd_if.cmd_ready, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk("reset_live", live, 0);
   endtask

   task automatic clear_board();
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            board[r][c] = 1'b0;
   endtask

   task automatic fill_board();
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            board[r][c] = (r >= 6 && r < H && c < W) ? 1'($urandom % 6 == 0) : 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int dr, dc, c, sel;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd       = 3'd0;
      clear_board();
      model_reset();

      // Reset values after a multi-cycle reset.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_vals("init");

      // SPAWN on empty board, LEFT to the wall, then ROT full circle.
      run_cmd(4);
      repeat (4) run_cmd(0);
      repeat (4) run_cmd(2);

      // DOWN blocked only by the third probed cell: lock, then LEFT rejected.
      blk_off(m_rot, 2, dr, dc);
      board[(m_row + 1 + dr + 32) % 32][(m_col + dc + 32) % 32] = 1'b1;
      run_cmd(3);
      run_cmd(0);

      // Blocked spawn point: game over, sticky.
      clear_board();
      board[1][4] = 1'b1;
      run_cmd(4);
      run_cmd(4);
      run_cmd(1);

      // Reset during PROBE idx 2 aborts without a result.
      clear_board();
      @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd       = 3'd4;
      @(posedge clk); #1;
      cmd_if.cmd_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("midrst_probe", rd_en, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("midrst");
      rst = 1'b0;
      model_reset();
      begin
         bit seen = 0;
         for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (cmd_if.res_valid !== 1'b0) seen = 1;
         end
         chk("midrst_no_result", seen, 0);
      end
      chk("midrst_ready", cmd_if.cmd_ready, 1);

      // Randomized command stream against the reference model.
      for (int i = 0; i < 90; i++) begin
         if (i % 12 == 0) fill_board();
         if (m_go != 0 && ($urandom % 3 == 0)) do_reset();
         sel = int'($urandom % 16);
         c = (sel < 4) ? 0 : (sel < 8) ? 1 : (sel < 11) ? 2 : (sel < 14) ? 3 :
             (sel < 15) ? 4 : 5 + int'($urandom % 3);
         if (m_live == 0 && ($urandom % 4 != 0)) c = 4;
         run_cmd(c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
